// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: opcodes, FSM states and
// the iteration count of the radix-2 datapath.
package md_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110,
    OP_RSVD  = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  localparam int         ITERS    = 32;
  localparam logic [4:0] CNT_LAST = 5'(ITERS - 1);

endpackage

// File: rtl/md_iter_core.sv
// 64-bit shift/accumulate datapath: one shift-add multiply step or one
// restoring divide step per enabled cycle, operating on unsigned magnitudes.
module md_iter_core (
  input  logic        clk,
  input  logic        i_load,
  input  logic        i_step,
  input  logic        i_is_div,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_m;
  logic [32:0] w_sum;
  logic [32:0] w_shift;
  logic [32:0] w_diff;

  // Multiply: hi accumulates, lo holds the multiplier shifting out LSB-first.
  // Divide: hi is the partial remainder, lo the dividend/quotient shifting left.
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : 33'd0);
  assign w_shift = {r_hi, r_lo[31]};
  assign w_diff  = w_shift - {1'b0, r_m};

  // NOTE: pure datapath registers carry no reset; the controlling FSM never
  // exposes them until a load has initialised them, so a reset net buys nothing.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_hi <= '0;
      r_lo <= i_a;
      r_m  <= i_b;
    end else if (i_step) begin
      if (i_is_div) begin
        if (!w_diff[32]) begin
          r_hi <= w_diff[31:0];
          r_lo <= {r_lo[30:0], 1'b1};
        end else begin
          r_hi <= w_shift[31:0];
          r_lo <= {r_lo[30:0], 1'b0};
        end
      end else begin
        r_hi <= w_sum[32:1];
        r_lo <= {w_sum[0], r_lo[31:1]};
      end
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers:
// control FSM, operand sign handling and result correction.
module md_unit
  import md_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  md_control,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic        Flush,
  output logic        Busy,
  output logic        md_signal,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  md_state_e   r_state;
  md_state_e   w_next_state;
  logic [4:0]  r_cnt;
  logic        r_is_div;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_div_zero;
  logic        r_mt_pulse;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_res_hi;
  logic [31:0] r_res_lo;

  md_op_e      w_op;
  logic        w_calc_op;
  logic        w_signed_op;
  logic        w_div_op;
  logic        w_load;
  logic        w_mt_hi;
  logic        w_mt_lo;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_core_hi;
  logic [31:0] w_core_lo;
  logic [63:0] w_prod;
  logic [31:0] w_fix_hi;
  logic [31:0] w_fix_lo;

  assign w_op        = md_op_e'(md_control);
  assign w_calc_op   = (w_op == OP_MULT) || (w_op == OP_MULTU) ||
                       (w_op == OP_DIV)  || (w_op == OP_DIVU);
  assign w_signed_op = (w_op == OP_MULT) || (w_op == OP_DIV);
  assign w_div_op    = (w_op == OP_DIV)  || (w_op == OP_DIVU);
  assign w_mag_a     = (w_signed_op && SrcA[31]) ? -SrcA : SrcA;
  assign w_mag_b     = (w_signed_op && SrcB[31]) ? -SrcB : SrcB;

  assign w_mt_hi = (r_state == ST_IDLE) && Start && !Flush && (w_op == OP_MTHI);
  assign w_mt_lo = (r_state == ST_IDLE) && Start && !Flush && (w_op == OP_MTLO);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: if (Start && w_calc_op) begin
        w_next_state = ST_CALC;
        w_load       = 1'b1;
      end
      ST_CALC: if (r_cnt == CNT_LAST) w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
    if (Flush) begin
      w_next_state = ST_IDLE;
      w_load       = 1'b0;
    end
  end

  md_iter_core u_core (
    .clk      (Clk),
    .i_load   (w_load),
    .i_step   (r_state == ST_CALC),
    .i_is_div (w_div_op && w_load ? 1'b1 : r_is_div && !w_load),
    .i_a      (w_mag_a),
    .i_b      (w_mag_b),
    .o_hi     (w_core_hi),
    .o_lo     (w_core_lo)
  );

  // Divide by zero leaves the dividend magnitude in the remainder, so only the
  // quotient needs overriding; the remainder's sign fix restores SrcA.
  always_comb begin
    w_prod   = {w_core_hi, w_core_lo};
    w_fix_hi = w_core_hi;
    w_fix_lo = w_core_lo;
    if (r_is_div) begin
      w_fix_lo = r_div_zero ? 32'hFFFF_FFFF : (r_neg_q ? -w_core_lo : w_core_lo);
      w_fix_hi = r_neg_r ? -w_core_hi : w_core_hi;
    end else begin
      if (r_neg_q) w_prod = -w_prod;
      w_fix_hi = w_prod[63:32];
      w_fix_lo = w_prod[31:0];
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_mt_pulse <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_res_hi   <= '0;
      r_res_lo   <= '0;
    end else begin
      r_state    <= w_next_state;
      r_mt_pulse <= w_mt_hi || w_mt_lo;
      if (w_load) begin
        r_cnt      <= '0;
        r_is_div   <= w_div_op;
        r_neg_q    <= w_signed_op && (SrcA[31] ^ SrcB[31]);
        r_neg_r    <= (w_op == OP_DIV) && SrcA[31];
        r_div_zero <= w_div_op && (SrcB == 32'd0);
      end else if (r_state == ST_CALC) begin
        r_cnt <= r_cnt + 5'd1;
      end
      if (w_mt_hi) begin
        r_hi     <= SrcA;
        r_res_hi <= SrcA;
        r_res_lo <= r_lo;
      end
      if (w_mt_lo) begin
        r_lo     <= SrcA;
        r_res_hi <= r_hi;
        r_res_lo <= SrcA;
      end
      if ((r_state == ST_DONE) && !Flush) begin
        r_hi     <= w_fix_hi;
        r_lo     <= w_fix_lo;
        r_res_hi <= w_fix_hi;
        r_res_lo <= w_fix_lo;
      end
    end
  end

  assign Busy      = (r_state != ST_IDLE);
  assign md_signal = (r_state == ST_DONE) || r_mt_pulse;
  assign res_hi    = (r_state == ST_DONE) ? w_fix_hi : r_res_hi;
  assign res_lo    = (r_state == ST_DONE) ? w_fix_lo : r_res_lo;
  assign HI        = r_hi;
  assign LO        = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_md_unit;

  localparam logic [2:0] C_NOP   = 3'b000;
  localparam logic [2:0] C_MULT  = 3'b001;
  localparam logic [2:0] C_MULTU = 3'b010;
  localparam logic [2:0] C_DIV   = 3'b011;
  localparam logic [2:0] C_DIVU  = 3'b100;
  localparam logic [2:0] C_MTHI  = 3'b101;
  localparam logic [2:0] C_MTLO  = 3'b110;
  localparam logic [2:0] C_RSVD  = 3'b111;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [2:0]  md_control;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Flush;
  logic        Busy;
  logic        md_signal;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic [31:0] HI;
  logic [31:0] LO;

  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          n_tests = 0;
  int          n_fail  = 0;

  md_unit dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .md_control (md_control),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .Flush      (Flush),
    .Busy       (Busy),
    .md_signal  (md_signal),
    .res_hi     (res_hi),
    .res_lo     (res_lo),
    .HI         (HI),
    .LO         (LO)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] q;
    logic signed [63:0] r;
    logic [63:0]        p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    p  = '0;
    case (op)
      C_MULT:  p = sa * sb;
      C_MULTU: p = {32'd0, a} * {32'd0, b};
      C_DIV: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      C_DIVU: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else p = {32'(a % b), 32'(a / b)};
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'd1;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit hold);
    logic [63:0] exp;
    int          n;
    md_control = op;
    SrcA       = a;
    SrcB       = b;
    Start      = 1'b1;
    @(posedge Clk); #1;
    if (!hold) Start = 1'b0;
    case (op)
      C_MULT, C_MULTU, C_DIV, C_DIVU: begin
        exp = ref_result(op, a, b);
        check("busy_calc", 64'(Busy), 64'd1);
        n = 1;
        while (!md_signal && n < 40) begin
          @(posedge Clk); #1;
          n++;
        end
        Start = 1'b0;
        check("latency", 64'(n), 64'd33);
        check("result", {res_hi, res_lo}, exp);
        check("busy_done", 64'(Busy), 64'd1);
        @(posedge Clk); #1;
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        check("hilo", {HI, LO}, {m_hi, m_lo});
        check("idle_after", {62'd0, Busy, md_signal}, 64'd0);
        check("res_hold", {res_hi, res_lo}, exp);
      end
      C_MTHI, C_MTLO: begin
        if (op == C_MTHI) m_hi = a;
        else              m_lo = a;
        Start = 1'b0;
        check("mt_busy", 64'(Busy), 64'd0);
        check("mt_pulse", 64'(md_signal), 64'd1);
        check("mt_res", {res_hi, res_lo}, {m_hi, m_lo});
        check("mt_hilo", {HI, LO}, {m_hi, m_lo});
        @(posedge Clk); #1;
        check("mt_pulse_end", 64'(md_signal), 64'd0);
      end
      default: begin
        Start = 1'b0;
        check("nop_idle", {62'd0, Busy, md_signal}, 64'd0);
        check("nop_hilo", {HI, LO}, {m_hi, m_lo});
      end
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    Reset      = 1'b0;
    Start      = 1'b0;
    Flush      = 1'b0;
    md_control = C_NOP;
    SrcA       = '0;
    SrcB       = '0;
    m_hi       = '0;
    m_lo       = '0;
    #2;
    check("reset_ctl", {62'd0, Busy, md_signal}, 64'd0);
    check("reset_res", {res_hi, res_lo}, 64'd0);
    check("reset_hilo", {HI, LO}, 64'd0);
    #10 Reset = 1'b1;
    @(posedge Clk); #1;

    do_op(C_MULT,  32'hFFFF_FFFD, 32'd7,        1'b0);
    check("mult_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_const", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
    do_op(C_DIV,   32'hFFFF_FFF9, 32'd2,        1'b0);
    check("div_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(C_DIVU,  32'd5,         32'd0,        1'b0);
    check("divu_zero_const", {HI, LO}, 64'h0000_0005_FFFF_FFFF);
    do_op(C_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    check("div_ovf_const", {HI, LO}, 64'h0000_0000_8000_0000);
    do_op(C_DIV,   32'hFFFF_FFF9, 32'd0,        1'b0);

    // Back-to-back MTHI / MTLO
    md_control = C_MTHI; SrcA = 32'h1234_5678; Start = 1'b1;
    @(posedge Clk); #1;
    m_hi = 32'h1234_5678;
    check("mthi_busy", 64'(Busy), 64'd0);
    check("mthi_pulse", 64'(md_signal), 64'd1);
    check("mthi_res", {res_hi, res_lo}, {m_hi, m_lo});
    md_control = C_MTLO; SrcA = 32'h9ABC_DEF0;
    @(posedge Clk); #1;
    Start = 1'b0;
    m_lo = 32'h9ABC_DEF0;
    check("mtlo_busy", 64'(Busy), 64'd0);
    check("mtlo_pulse", 64'(md_signal), 64'd1);
    check("mtlo_res", {res_hi, res_lo}, {m_hi, m_lo});
    check("mt_pair_hilo", {HI, LO}, 64'h1234_5678_9ABC_DEF0);
    @(posedge Clk); #1;
    check("mt_pair_end", 64'(md_signal), 64'd0);

    do_op(C_NOP,  32'hDEAD_BEEF, 32'd3, 1'b0);
    do_op(C_RSVD, 32'hDEAD_BEEF, 32'd3, 1'b0);

    // Flush at CALC iteration 10
    md_control = C_DIVU; SrcA = 32'd100; SrcB = 32'd7; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (10) @(posedge Clk);
    #1 Flush = 1'b1;
    @(posedge Clk); #1;
    Flush = 1'b0;
    check("flush_busy", 64'(Busy), 64'd0);
    check("flush_sig", 64'(md_signal), 64'd0);
    check("flush_hilo", {HI, LO}, {m_hi, m_lo});
    do_op(C_MULTU, 32'd100, 32'd7, 1'b0);

    // Flush in the DONE cycle
    md_control = C_DIVU; SrcA = 32'd1000; SrcB = 32'd9; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    n = 1;
    while (!md_signal && n < 40) begin
      @(posedge Clk); #1;
      n++;
    end
    check("fdone_latency", 64'(n), 64'd33);
    Flush = 1'b1;
    @(posedge Clk); #1;
    Flush = 1'b0;
    check("fdone_busy", 64'(Busy), 64'd0);
    check("fdone_hilo", {HI, LO}, {m_hi, m_lo});

    // Async reset mid-CALC with Start held high
    md_control = C_MULT; SrcA = 32'hFFFF_FFFD; SrcB = 32'd7; Start = 1'b1;
    @(posedge Clk); #1;
    repeat (5) @(posedge Clk);
    #1;
    check("hold_busy", 64'(Busy), 64'd1);
    check("hold_sig", 64'(md_signal), 64'd0);
    #2 Reset = 1'b0;
    #1;
    check("arst_ctl", {62'd0, Busy, md_signal}, 64'd0);
    check("arst_res", {res_hi, res_lo}, 64'd0);
    check("arst_hilo", {HI, LO}, 64'd0);
    m_hi = '0;
    m_lo = '0;
    #1 Reset = 1'b1;
    do_op(C_MULTU, 32'd3, 32'd4, 1'b0);

    // Randomized operations
    for (int i = 0; i < 60; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      do_op(op, pick(), pick(), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
